// File: rtl/dense_layer_engine_if.sv
// Control, configuration and scratchpad-port bundle of the dense layer engine.
// The sequencer/testbench side uses master; the engine uses slave.
interface dense_layer_engine_if #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 16,
    parameter int SIZE_W  = 10,
    parameter int LANES   = 4,
    parameter int SHIFT_W = 4
);
    logic                       start;
    logic                       relu_en;
    logic [SHIFT_W-1:0]         shift;
    logic [ADDR_W-1:0]          input_base;
    logic [ADDR_W-1:0]          weight_base;
    logic [ADDR_W-1:0]          bias_base;
    logic [ADDR_W-1:0]          output_base;
    logic [SIZE_W-1:0]          m_size;
    logic [SIZE_W-1:0]          chw_size;
    logic                       busy;
    logic                       done;
    logic                       in_rd_en;
    logic [ADDR_W-1:0]          in_rd_addr;
    logic signed [DATA_W-1:0]   in_rd_data;
    logic                       w_rd_en;
    logic [ADDR_W-1:0]          w_rd_addr;
    logic [LANES*DATA_W-1:0]    w_rd_data;
    logic                       b_rd_en;
    logic [ADDR_W-1:0]          b_rd_addr;
    logic [LANES*DATA_W-1:0]    b_rd_data;
    logic                       out_wr_en;
    logic [ADDR_W-1:0]          out_wr_addr;
    logic signed [DATA_W-1:0]   out_wr_data;

    modport master (
        output start, relu_en, shift, input_base, weight_base, bias_base, output_base,
               m_size, chw_size, in_rd_data, w_rd_data, b_rd_data,
        input  busy, done, in_rd_en, in_rd_addr, w_rd_en, w_rd_addr, b_rd_en, b_rd_addr,
               out_wr_en, out_wr_addr, out_wr_data
    );

    modport slave (
        input  start, relu_en, shift, input_base, weight_base, bias_base, output_base,
               m_size, chw_size, in_rd_data, w_rd_data, b_rd_data,
        output busy, done, in_rd_en, in_rd_addr, w_rd_en, w_rd_addr, b_rd_en, b_rd_addr,
               out_wr_en, out_wr_addr, out_wr_data
    );
endinterface

// File: rtl/dense_layer_engine.sv
// Multi-lane fully connected layer engine: bias init, MAC over the input vector,
// then requantised serial write-back of LANES outputs per group.
module dense_layer_engine #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int ADDR_W  = 16,
    parameter int SIZE_W  = 10,
    parameter int LANES   = 4,
    parameter int SHIFT_W = 4
) (
    input logic clk,
    input logic rst,
    dense_layer_engine_if.slave bus
);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;

    typedef enum logic [2:0] {IDLE, BIAS, MAC, FLUSH, WRITE, DONE} state_t;

    state_t                     state;
    logic                       relu_q;
    logic [SHIFT_W-1:0]         shift_q;
    logic [ADDR_W-1:0]          in_base_q;
    logic [ADDR_W-1:0]          out_base_q;
    logic [SIZE_W-1:0]          m_q;
    logic [SIZE_W-1:0]          chw_q;
    logic [SIZE_W-1:0]          k;
    logic [SIZE_W-1:0]          out_cnt;
    logic [SIZE_W-1:0]          out_cnt_nx;
    logic [LANE_W-1:0]          lane;
    logic [LANE_W-1:0]          wr_sel;
    logic [ADDR_W-1:0]          w_ptr;
    logic [ADDR_W-1:0]          b_ptr;
    logic                       vld_bias_p1;
    logic                       vld_mac_p1;
    logic signed [ACC_W-1:0]    acc [LANES];
    logic signed [ACC_W-1:0]    acc_nxt [LANES];
    logic signed [2*DATA_W-1:0] prod [LANES];
    logic signed [DATA_W-1:0]   rq [LANES];
    logic signed [DATA_W-1:0]   wr_data;

    // Floor shift, optional ReLU, then clamp into the output element range.
    function automatic logic signed [DATA_W-1:0] requant(input logic signed [ACC_W-1:0] a,
                                                         input logic [SHIFT_W-1:0] sh,
                                                         input logic relu);
        logic signed [ACC_W-1:0] v;
        v = a >>> sh;
        if (relu && v[ACC_W-1]) v = '0;
        if (v > ACC_MAX) return ACC_MAX[DATA_W-1:0];
        if (v < ACC_MIN) return ACC_MIN[DATA_W-1:0];
        return v[DATA_W-1:0];
    endfunction

    assign out_cnt_nx = out_cnt + 1'b1;

    // Stage p1: memory data returned for last cycle's request folds into the accumulators.
    always_comb begin
        wr_sel  = (state == FLUSH) ? '0 : lane + 1'b1;
        wr_data = '0;
        for (int l = 0; l < LANES; l++) begin
            prod[l]    = signed'(bus.w_rd_data[l*DATA_W +: DATA_W]) * bus.in_rd_data;
            acc_nxt[l] = acc[l];
            if (vld_bias_p1)
                acc_nxt[l] = ACC_W'(signed'(bus.b_rd_data[l*DATA_W +: DATA_W])) <<< shift_q;
            else if (vld_mac_p1)
                acc_nxt[l] = acc[l] + ACC_W'(prod[l]);
            rq[l] = requant(acc_nxt[l], shift_q, relu_q);
            if (LANE_W'(l) == wr_sel) wr_data = rq[l];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.in_rd_en    <= 1'b0;
            bus.in_rd_addr  <= '0;
            bus.w_rd_en     <= 1'b0;
            bus.w_rd_addr   <= '0;
            bus.b_rd_en     <= 1'b0;
            bus.b_rd_addr   <= '0;
            bus.out_wr_en   <= 1'b0;
            bus.out_wr_addr <= '0;
            bus.out_wr_data <= '0;
            relu_q          <= 1'b0;
            shift_q         <= '0;
            in_base_q       <= '0;
            out_base_q      <= '0;
            m_q             <= '0;
            chw_q           <= '0;
            k               <= '0;
            out_cnt         <= '0;
            lane            <= '0;
            w_ptr           <= '0;
            b_ptr           <= '0;
            vld_bias_p1     <= 1'b0;
            vld_mac_p1      <= 1'b0;
            acc             <= '{default: '0};
        end else begin
            bus.in_rd_en  <= 1'b0;
            bus.w_rd_en   <= 1'b0;
            bus.b_rd_en   <= 1'b0;
            bus.out_wr_en <= 1'b0;
            bus.done      <= 1'b0;
            vld_bias_p1   <= bus.b_rd_en;
            vld_mac_p1    <= bus.in_rd_en;
            acc           <= acc_nxt;
            case (state)
                IDLE: if (bus.start) begin
                    relu_q     <= bus.relu_en;
                    shift_q    <= bus.shift;
                    in_base_q  <= bus.input_base;
                    out_base_q <= bus.output_base;
                    m_q        <= bus.m_size;
                    chw_q      <= bus.chw_size;
                    w_ptr      <= bus.weight_base;
                    b_ptr      <= bus.bias_base;
                    out_cnt    <= '0;
                    bus.busy   <= 1'b1;
                    if (bus.m_size == '0) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else begin
                        state         <= BIAS;
                        bus.b_rd_en   <= 1'b1;
                        bus.b_rd_addr <= bus.bias_base;
                    end
                end
                BIAS: begin
                    b_ptr <= b_ptr + 1'b1;
                    if (chw_q == '0) begin
                        state <= FLUSH;
                    end else begin
                        state          <= MAC;
                        bus.in_rd_en   <= 1'b1;
                        bus.in_rd_addr <= in_base_q;
                        bus.w_rd_en    <= 1'b1;
                        bus.w_rd_addr  <= w_ptr;
                        w_ptr          <= w_ptr + 1'b1;
                        k              <= SIZE_W'(1);
                    end
                end
                MAC: begin
                    if (k == chw_q) begin
                        state <= FLUSH;
                    end else begin
                        bus.in_rd_en   <= 1'b1;
                        bus.in_rd_addr <= in_base_q + ADDR_W'(k);
                        bus.w_rd_en    <= 1'b1;
                        bus.w_rd_addr  <= w_ptr;
                        w_ptr          <= w_ptr + 1'b1;
                        k              <= k + 1'b1;
                    end
                end
                FLUSH: begin
                    state           <= WRITE;
                    lane            <= '0;
                    bus.out_wr_en   <= 1'b1;
                    bus.out_wr_addr <= out_base_q + ADDR_W'(out_cnt);
                    bus.out_wr_data <= wr_data;
                end
                WRITE: begin
                    out_cnt <= out_cnt_nx;
                    if (lane == LANE_W'(LANES - 1) || out_cnt_nx == m_q) begin
                        if (out_cnt_nx != m_q) begin
                            state         <= BIAS;
                            bus.b_rd_en   <= 1'b1;
                            bus.b_rd_addr <= b_ptr;
                        end else begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end
                    end else begin
                        lane            <= lane + 1'b1;
                        bus.out_wr_en   <= 1'b1;
                        bus.out_wr_addr <= out_base_q + ADDR_W'(out_cnt_nx);
                        bus.out_wr_data <= wr_data;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dense_layer_engine.sv
// Directed bench for dense_layer_engine with behavioural scratchpads and a
// negedge monitor that logs strobes, addresses and cycle numbers per run.
module tb_dense_layer_engine;
    localparam int DATA_W = 8, ACC_W = 24, ADDR_W = 16, SIZE_W = 10, LANES = 4, SHIFT_W = 4;
    localparam int IN_B = 16'h0010, W_B = 16'h0040, B_B = 16'h0020, O_B = 16'h0080;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dense_layer_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W),
                            .LANES(LANES), .SHIFT_W(SHIFT_W)) bus ();
    dense_layer_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W),
                         .LANES(LANES), .SHIFT_W(SHIFT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0]  in_mem [256];
    logic [31:0] w_mem  [256];
    logic [31:0] b_mem  [256];

    always @(posedge clk) begin
        if (bus.in_rd_en) bus.in_rd_data <= in_mem[bus.in_rd_addr[7:0]];
        if (bus.w_rd_en)  bus.w_rd_data  <= w_mem[bus.w_rd_addr[7:0]];
        if (bus.b_rd_en)  bus.b_rd_data  <= b_mem[bus.b_rd_addr[7:0]];
    end

    int cyc, n_wr, n_b, n_w, n_in, n_done, done_cyc;
    int wr_addr [64], wr_data [64], wr_cyc [64], b_addr [16], w_addr [64];
    int n_chk = 0, n_err = 0;
    int exp_v [8];

    always @(negedge clk) begin
        cyc++;
        if (bus.out_wr_en) begin
            if (n_wr < 64) begin
                wr_addr[n_wr] = int'(bus.out_wr_addr);
                wr_data[n_wr] = int'(bus.out_wr_data);
                wr_cyc[n_wr]  = cyc;
            end
            n_wr++;
        end
        if (bus.b_rd_en) begin
            if (n_b < 16) b_addr[n_b] = int'(bus.b_rd_addr);
            n_b++;
        end
        if (bus.w_rd_en) begin
            if (n_w < 64) w_addr[n_w] = int'(bus.w_rd_addr);
            n_w++;
        end
        if (bus.in_rd_en) n_in++;
        if (bus.done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        cyc = 0; n_wr = 0; n_b = 0; n_w = 0; n_in = 0; n_done = 0; done_cyc = -1;
    endtask

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic set_cfg(input int m, input int chw, input int sh, input int relu);
        bus.m_size      = SIZE_W'(m);
        bus.chw_size    = SIZE_W'(chw);
        bus.shift       = SHIFT_W'(sh);
        bus.relu_en     = relu[0];
        bus.input_base  = ADDR_W'(IN_B);
        bus.weight_base = ADDR_W'(W_B);
        bus.bias_base   = ADDR_W'(B_B);
        bus.output_base = ADDR_W'(O_B);
    endtask

    // Start is sampled at edge 0; cycle n is the cycle after edge n-1.
    task automatic run(input int m, input int chw, input int sh, input int relu);
        set_cfg(m, chw, sh, relu);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        clear_log();
        for (int i = 0; i < 3000 && n_done == 0; i++) @(posedge clk);
        #1;
        if (n_done == 0) chk("timeout_done", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_writes(input string tag, input int n);
        chk({tag, "_nwr"}, n_wr, n);
        for (int i = 0; i < n && i < n_wr; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wr_addr[i], O_B + i);
            chk($sformatf("%s_data%0d", tag, i), wr_data[i], exp_v[i]);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        set_cfg(0, 0, 0, 0);
        clear_log();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_wr_en", int'(bus.out_wr_en), 0);
        chk("rst_b_rd_en", int'(bus.b_rd_en), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic dot products with signed biases and exact cycle timing.
        in_mem[16] = 8'd1; in_mem[17] = 8'd2; in_mem[18] = 8'd3;
        for (int i = 0; i < 3; i++) w_mem[W_B + i] = pack4(1, 1, 1, 1);
        b_mem[B_B] = pack4(0, 1, -1, 5);
        exp_v[0] = 6; exp_v[1] = 7; exp_v[2] = 5; exp_v[3] = 11;
        run(4, 3, 0, 0);
        chk_writes("t1", 4);
        for (int i = 0; i < 4 && i < n_wr; i++) chk($sformatf("t1_cyc%0d", i), wr_cyc[i], 6 + i);
        chk("t1_done_cyc", done_cyc, 10);
        chk("t1_n_done", n_done, 1);
        chk("t1_n_in", n_in, 3);
        chk("t1_n_b", n_b, 1);

        // Positive and negative saturation.
        for (int i = 0; i < 4; i++) begin
            in_mem[16 + i]  = 8'd127;
            w_mem[W_B + i]  = pack4(127, 127, 127, 127);
        end
        b_mem[B_B] = 32'h0;
        exp_v[0] = 127; exp_v[1] = 127;
        run(2, 4, 0, 0);
        chk_writes("t2p", 2);
        for (int i = 0; i < 4; i++) w_mem[W_B + i] = pack4(-128, -128, -128, -128);
        exp_v[0] = -128; exp_v[1] = -128;
        run(2, 4, 0, 0);
        chk_writes("t2n", 2);

        // Single output, ReLU on and off, partial last group.
        in_mem[16] = 8'd0; in_mem[17] = 8'd0;
        w_mem[W_B] = pack4(1, 1, 1, 1); w_mem[W_B + 1] = pack4(1, 1, 1, 1);
        b_mem[B_B] = pack4(-10, 0, 0, 0);
        exp_v[0] = 0;
        run(1, 2, 0, 1);
        chk_writes("t3r", 1);
        exp_v[0] = -10;
        run(1, 2, 0, 0);
        chk_writes("t3n", 1);

        // Two groups: bias/weight addressing across groups.
        in_mem[16] = 8'd1; in_mem[17] = 8'd1;
        for (int i = 0; i < 4; i++) w_mem[W_B + i] = pack4(1, 1, 1, 1);
        b_mem[B_B] = 32'h0;
        b_mem[B_B + 1] = pack4(3, 0, 0, 0);
        exp_v[0] = 2; exp_v[1] = 2; exp_v[2] = 2; exp_v[3] = 2; exp_v[4] = 5;
        run(5, 2, 0, 0);
        chk_writes("t4", 5);
        chk("t4_n_b", n_b, 2);
        chk("t4_b_addr0", b_addr[0], B_B);
        chk("t4_b_addr1", b_addr[1], B_B + 1);
        chk("t4_n_w", n_w, 4);
        chk("t4_w_addr2", w_addr[2], W_B + 2);
        chk("t4_w_addr3", w_addr[3], W_B + 3);
        chk("t4_done_cyc", done_cyc, 14);

        // Requantisation shift with floor rounding, and chw=0.
        in_mem[16] = 8'd1;
        w_mem[W_B] = pack4(7, -7, 0, 0);
        b_mem[B_B] = 32'h0;
        exp_v[0] = 1; exp_v[1] = -2;
        run(2, 1, 2, 0);
        chk_writes("t5s", 2);
        b_mem[B_B] = pack4(1, 0, 0, 0);
        exp_v[0] = 1;
        run(1, 0, 2, 0);
        chk_writes("t5z", 1);
        chk("t5z_n_in", n_in, 0);
        chk("t5z_n_w", n_w, 0);
        chk("t5z_done_cyc", done_cyc, 4);

        // Empty layer.
        run(0, 3, 0, 0);
        chk("m0_n_done", n_done, 1);
        chk("m0_done_cyc", done_cyc, 1);
        chk("m0_n_wr", n_wr, 0);
        chk("m0_n_b", n_b, 0);

        // Asynchronous reset in the middle of a long MAC phase.
        set_cfg(4, 100, 0, 0);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_busy", int'(bus.busy), 0);
        chk("t6_rst_in_rd", int'(bus.in_rd_en), 0);
        chk("t6_rst_w_rd", int'(bus.w_rd_en), 0);
        chk("t6_rst_wr_en", int'(bus.out_wr_en), 0);
        chk("t6_rst_done", int'(bus.done), 0);
        clear_log();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (150) @(posedge clk);
        #1;
        chk("t6_post_nwr", n_wr, 0);
        chk("t6_post_done", n_done, 0);
        chk("t6_post_busy", int'(bus.busy), 0);

        // Start (and a config change) while busy must not launch another run.
        set_cfg(1, 5, 0, 0);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        clear_log();
        repeat (3) @(posedge clk);
        #1;
        bus.m_size = SIZE_W'(4);
        bus.start  = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("t6_busy_start_nwr", n_wr, 1);
        chk("t6_busy_start_done", n_done, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
